// File: rtl/dff_reset_en_async.sv
// Holding register with load enable, synchronous clear and asynchronous active-low reset.
// loaded_o tells the owner whether data_o holds a captured word or only the reset value.
module dff_reset_en_async #(
  parameter int                 width_p     = 64,
  parameter logic [width_p-1:0] reset_val_p = '0
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               en_i,
  input  logic               clear_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o,
  output logic               loaded_o
);

  if (width_p < 1) begin : g_bad_width
    $error("dff_reset_en_async: width_p must be at least 1");
  end

  logic [width_p-1:0] r_data_p0;
  logic               r_loaded_p0;

  // Stage p0: clear beats load, and reset beats both without waiting for a clock edge.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_data_p0   <= reset_val_p;
      r_loaded_p0 <= 1'b0;
    end else if (clear_i) begin
      r_data_p0   <= reset_val_p;
      r_loaded_p0 <= 1'b0;
    end else if (en_i) begin
      r_data_p0   <= data_i;
      r_loaded_p0 <= 1'b1;
    end
  end

  assign data_o   = r_data_p0;
  assign loaded_o = r_loaded_p0;

endmodule

// File: tb/tb_dff_reset_en_async.sv
// Scoreboard bench for dff_reset_en_async: an 8-bit instance (reset value A5) and a
// 600-bit instance (reset value 0) share clock and reset; a monitor drains expectations.
module tb_dff_reset_en_async;

  localparam int WW = 600;

  typedef struct {
    logic [WW-1:0] d;
    logic          l;
    bit            wide;
    string         nm;
  } exp_t;

  logic          clk_i = 1'b0;
  logic          rst_n = 1'b1;
  logic          en8 = 1'b0, clr8 = 1'b0;
  logic [7:0]    d8 = '0;
  logic [7:0]    q8;
  logic          ld8;
  logic          enw = 1'b0, clrw = 1'b0;
  logic [WW-1:0] dw = '0;
  logic [WW-1:0] qw;
  logic          ldw;

  exp_t q[$];
  event async_ev;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk_i = ~clk_i;

  dff_reset_en_async #(.width_p(8), .reset_val_p(8'hA5)) u_dut8 (
    .clk_i(clk_i), .reset_n_i(rst_n), .en_i(en8), .clear_i(clr8),
    .data_i(d8), .data_o(q8), .loaded_o(ld8)
  );

  dff_reset_en_async #(.width_p(WW)) u_dutw (
    .clk_i(clk_i), .reset_n_i(rst_n), .en_i(enw), .clear_i(clrw),
    .data_i(dw), .data_o(qw), .loaded_o(ldw)
  );

  task automatic push8(input logic [7:0] ed, input logic el, input string nm);
    exp_t e;
    e.d = '0; e.d[7:0] = ed; e.l = el; e.wide = 1'b0; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic pushw(input logic [WW-1:0] ed, input logic el, input string nm);
    exp_t e;
    e.d = ed; e.l = el; e.wide = 1'b1; e.nm = nm;
    q.push_back(e);
  endtask

  // One narrow vector: inputs change on the falling edge, result expected after the next rise.
  task automatic drv8(input logic rn, input logic en, input logic clr, input logic [7:0] d,
                      input logic [7:0] ed, input logic el, input string nm);
    @(negedge clk_i);
    rst_n = rn; en8 = en; clr8 = clr; d8 = d;
    push8(ed, el, nm);
  endtask

  task automatic drvw(input logic en, input logic clr, input logic [WW-1:0] d,
                      input logic [WW-1:0] ed, input logic el, input string nm);
    @(negedge clk_i);
    enw = en; clrw = clr; dw = d;
    pushw(ed, el, nm);
  endtask

  // Monitor: compares every queued expectation after each rising edge or async check point.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i or async_ev);
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        if (e.wide) begin
          if (qw !== e.d || ldw !== e.l) begin
            n_bad++;
            $display("FAIL %s: got data=%h loaded=%b, want data=%h loaded=%b",
                     e.nm, qw, ldw, e.d, e.l);
          end
        end else begin
          if (q8 !== e.d[7:0] || ld8 !== e.l) begin
            n_bad++;
            $display("FAIL %s: got data=%h loaded=%b, want data=%h loaded=%b",
                     e.nm, q8, ld8, e.d[7:0], e.l);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WW-1:0] alt, m_d, rnd;
    logic [607:0]  tmp;
    logic          m_l, r_en, r_clr;

    // Reset asserted between edges must show up without any clock edge.
    @(negedge clk_i);
    #2;
    rst_n = 1'b0; en8 = 1'b1; d8 = 8'hFF;
    #1;
    push8(8'hA5, 1'b0, "reset_immediate");
    -> async_ev;
    for (int i = 0; i < 3; i++) drv8(1'b0, 1'b1, 1'b0, 8'hFF, 8'hA5, 1'b0, "reset_hold");
    drv8(1'b1, 1'b0, 1'b0, 8'h00, 8'hA5, 1'b0, "reset_release");

    drv8(1'b1, 1'b1, 1'b0, 8'h3C, 8'h3C, 1'b1, "load_3c");
    for (int i = 0; i < 5; i++) drv8(1'b1, 1'b0, 1'b0, 8'h00, 8'h3C, 1'b1, "hold_3c");

    drv8(1'b1, 1'b1, 1'b0, 8'h01, 8'h01, 1'b1, "b2b_01");
    drv8(1'b1, 1'b1, 1'b0, 8'h02, 8'h02, 1'b1, "b2b_02");
    drv8(1'b1, 1'b1, 1'b0, 8'h03, 8'h03, 1'b1, "b2b_03");

    drv8(1'b1, 1'b1, 1'b1, 8'h77, 8'hA5, 1'b0, "clear_over_en");
    drv8(1'b1, 1'b1, 1'b0, 8'h77, 8'h77, 1'b1, "load_77");
    drv8(1'b1, 1'b1, 1'b0, 8'h77, 8'h77, 1'b1, "reload_same");
    drv8(1'b1, 1'b0, 1'b0, 8'hxx, 8'h77, 1'b1, "x_data_no_en");
    drv8(1'b1, 1'b0, 1'b1, 8'h55, 8'hA5, 1'b0, "clear_alone");
    drv8(1'b1, 1'b1, 1'b0, 8'h77, 8'h77, 1'b1, "reload_77");

    // Half-cycle reset pulse while a load is being presented.
    @(negedge clk_i);
    en8 = 1'b1; clr8 = 1'b0; d8 = 8'h12;
    rst_n = 1'b0;
    #1;
    push8(8'hA5, 1'b0, "reset_mid_op");
    -> async_ev;
    #3;
    rst_n = 1'b1;
    push8(8'h12, 1'b1, "first_edge_after_reset");
    drv8(1'b1, 1'b0, 1'b0, 8'h00, 8'h12, 1'b1, "hold_12");

    // Wide instance: alternating pattern, hold against its inverse, then clear.
    alt = {(WW/2){2'b01}};
    drvw(1'b0, 1'b0, alt, '0, 1'b0, "wide_after_reset");
    drvw(1'b1, 1'b0, alt, alt, 1'b1, "wide_alt_load");
    drvw(1'b0, 1'b0, ~alt, alt, 1'b1, "wide_alt_hold");
    drvw(1'b1, 1'b0, ~alt, ~alt, 1'b1, "wide_inv_load");
    drvw(1'b1, 1'b1, alt, '0, 1'b0, "wide_clear");

    m_d = '0;
    m_l = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      for (int k = 0; k < 19; k++) tmp[k*32 +: 32] = $urandom;
      rnd   = tmp[WW-1:0];
      r_en  = 1'($urandom_range(0, 1));
      r_clr = ($urandom_range(0, 7) == 0);
      if (r_clr) begin
        m_d = '0; m_l = 1'b0;
      end else if (r_en) begin
        m_d = rnd; m_l = 1'b1;
      end
      drvw(r_en, r_clr, rnd, m_d, m_l, "wide_random");
    end

    @(negedge clk_i);
    enw = 1'b0; clrw = 1'b0;
    @(negedge clk_i);
    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
